// File: rtl/serpentine_seq_pkg.sv
// serpentine_seq_pkg
//   Shared types and helpers for the serpentine chain valve sequencer.
//   - seq_state_e : sequencer FSM states
//   - stage_w()   : width of the stage index output for a given stage count
package serpentine_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPEN    = 2'd1,
    GAP     = 2'd2,
    COLLECT = 2'd3
  } seq_state_e;

  function automatic int stage_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/serpentine_chain_sequencer_dwell_timer.sv
// dwell_timer
//   Loadable unsigned down-counter shared by the OPEN dwell and GAP phases.
//   The owner loads (cycles-1); expired is high while the count is zero.
//   Ports:
//     clk, rst   clock, asynchronous active-high reset
//     load       load load_val (has priority over en)
//     en         decrement by one; holds at zero, never wraps
//     load_val   CNT_W value to load
//     expired    count is zero
module dwell_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/serpentine_chain_sequencer.sv
// serpentine_chain_sequencer
//   Timed valve sequencer for a chain of serpentine channel stages. Opens one
//   stage-inlet valve at a time for its programmed dwell, with all-closed gaps
//   between stages, repeats for the requested number of passes with an outlet
//   collection handshake after each pass, then pulses done.
//   Ports:
//     clk, rst     clock, asynchronous active-high reset
//     start        begin a run (IDLE only)
//     abort        terminate a run at once (highest priority)
//     dwell_cfg    stage k dwell in cycles at [k*CNT_W +: CNT_W]; 0 acts as 1
//     num_passes   passes through the chain; 0 acts as 1
//     out_ack      outlet collector accepts the sample
//     valve_open   one-hot or zero valve enables
//     stage_idx    current stage index
//     busy         run in progress
//     out_valid    sample ready at outlet, held until out_ack
//     done         one-cycle pulse on normal completion
//     aborted      one-cycle pulse when abort ends a run
module serpentine_chain_sequencer
  import serpentine_seq_pkg::*;
#(
  parameter int NUM_STAGES = 6,
  parameter int CNT_W      = 16,
  parameter int GAP_CYCLES = 4,
  parameter int PASS_W     = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              abort,
  input  logic [NUM_STAGES*CNT_W-1:0]       dwell_cfg,
  input  logic [PASS_W-1:0]                 num_passes,
  input  logic                              out_ack,
  output logic [NUM_STAGES-1:0]             valve_open,
  output logic [stage_w(NUM_STAGES)-1:0]    stage_idx,
  output logic                              busy,
  output logic                              out_valid,
  output logic                              done,
  output logic                              aborted
);

  localparam int                SW      = stage_w(NUM_STAGES);
  localparam logic [SW-1:0]     LAST    = SW'(NUM_STAGES - 1);
  localparam logic [CNT_W-1:0]  GAP_LD  = CNT_W'(GAP_CYCLES - 1);

  // Timer is loaded with (cycles - 1) so that it reads zero on the final cycle.
  function automatic logic [CNT_W-1:0] dwell_ld(input logic [CNT_W-1:0] d);
    return (d == '0) ? '0 : d - 1'b1;
  endfunction

  seq_state_e                  state_q, state_d;
  logic [SW-1:0]               stage_q, stage_d;
  logic [SW-1:0]               nxt_stage;
  logic [PASS_W-1:0]           pass_q, pass_d;
  logic [PASS_W:0]             pass_inc;
  logic [PASS_W-1:0]           passes_sh_q, passes_sh_d;
  logic [NUM_STAGES*CNT_W-1:0] dwell_sh_q, dwell_sh_d;
  logic                        restart_q, restart_d;
  logic [NUM_STAGES-1:0]       valve_open_q, valve_open_d;
  logic                        busy_q, busy_d;
  logic                        out_valid_q, out_valid_d;
  logic                        done_q, done_d;
  logic                        aborted_q, aborted_d;

  logic                        tmr_load, tmr_en, tmr_expired;
  logic [CNT_W-1:0]            tmr_val;

  dwell_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  always_comb begin
    state_d     = state_q;
    stage_d     = stage_q;
    nxt_stage   = stage_q;
    pass_d      = pass_q;
    passes_sh_d = passes_sh_q;
    dwell_sh_d  = dwell_sh_q;
    restart_d   = restart_q;
    done_d      = 1'b0;
    aborted_d   = 1'b0;
    tmr_load    = 1'b0;
    tmr_en      = 1'b0;
    tmr_val     = '0;
    pass_inc    = {1'b0, pass_q} + 1'b1;

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          dwell_sh_d  = dwell_cfg;
          passes_sh_d = (num_passes == '0) ? PASS_W'(1) : num_passes;
          stage_d     = '0;
          pass_d      = '0;
          restart_d   = 1'b0;
          tmr_load    = 1'b1;
          tmr_val     = dwell_ld(dwell_cfg[0 +: CNT_W]);
          state_d     = OPEN;
        end
      end
      OPEN: begin
        tmr_en = 1'b1;
        if (tmr_expired) begin
          tmr_load = 1'b1;
          tmr_val  = GAP_LD;
          state_d  = (stage_q == LAST) ? COLLECT : GAP;
        end
      end
      GAP: begin
        tmr_en = 1'b1;
        if (tmr_expired) begin
          // The gap that follows a collect already shows stage 0; it must not advance.
          nxt_stage = restart_q ? '0 : stage_q + 1'b1;
          stage_d   = nxt_stage;
          restart_d = 1'b0;
          tmr_load  = 1'b1;
          tmr_val   = dwell_ld(dwell_sh_q[nxt_stage*CNT_W +: CNT_W]);
          state_d   = OPEN;
        end
      end
      COLLECT: begin
        if (out_ack) begin
          if (pass_inc < {1'b0, passes_sh_q}) begin
            pass_d    = pass_inc[PASS_W-1:0];
            stage_d   = '0;
            restart_d = 1'b1;
            tmr_load  = 1'b1;
            tmr_val   = GAP_LD;
            state_d   = GAP;
          end else begin
            done_d  = 1'b1;
            stage_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort && (state_q != IDLE)) begin
      state_d   = IDLE;
      stage_d   = '0;
      restart_d = 1'b0;
      done_d    = 1'b0;
      aborted_d = 1'b1;
      tmr_load  = 1'b0;
    end

    // Outputs are decoded from the next state so they register on the same edge.
    for (int unsigned k = 0; k < NUM_STAGES; k++) begin
      valve_open_d[k] = (state_d == OPEN) && (stage_d == SW'(k));
    end
    busy_d      = (state_d != IDLE);
    out_valid_d = (state_d == COLLECT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      stage_q      <= '0;
      pass_q       <= '0;
      passes_sh_q  <= '0;
      dwell_sh_q   <= '0;
      restart_q    <= 1'b0;
      valve_open_q <= '0;
      busy_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      stage_q      <= stage_d;
      pass_q       <= pass_d;
      passes_sh_q  <= passes_sh_d;
      dwell_sh_q   <= dwell_sh_d;
      restart_q    <= restart_d;
      valve_open_q <= valve_open_d;
      busy_q       <= busy_d;
      out_valid_q  <= out_valid_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
    end
  end

  assign valve_open = valve_open_q;
  assign stage_idx  = stage_q;
  assign busy       = busy_q;
  assign out_valid  = out_valid_q;
  assign done       = done_q;
  assign aborted    = aborted_q;

endmodule

// File: tb/tb_serpentine_chain_sequencer.sv
module tb_serpentine_chain_sequencer;

  localparam int NS = 6;
  localparam int CW = 16;
  localparam int G  = 4;
  localparam int PW = 4;
  localparam int SW = $clog2(NS) + 1;

  logic               clk;
  logic               rst;
  logic               start;
  logic               abort;
  logic [NS*CW-1:0]   dwell_cfg;
  logic [PW-1:0]      num_passes;
  logic               out_ack;
  logic [NS-1:0]      valve_open;
  logic [SW-1:0]      stage_idx;
  logic               busy;
  logic               out_valid;
  logic               done;
  logic               aborted;

  int n_checks = 0;
  int n_fail   = 0;

  serpentine_chain_sequencer #(
    .NUM_STAGES (NS),
    .CNT_W      (CW),
    .GAP_CYCLES (G),
    .PASS_W     (PW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .dwell_cfg  (dwell_cfg),
    .num_passes (num_passes),
    .out_ack    (out_ack),
    .valve_open (valve_open),
    .stage_idx  (stage_idx),
    .busy       (busy),
    .out_valid  (out_valid),
    .done       (done),
    .aborted    (aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One expected cycle: outputs seen after an edge plus the inputs driven during it.
  typedef struct packed {
    logic [NS-1:0] v;
    logic [SW-1:0] s;
    logic          busy;
    logic          ov;
    logic          done;
    logic          ab;
    logic          ack;
    logic          abt;
  } exp_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [NS-1:0] v, input int s, input logic b,
                              input logic ov, input logic d, input logic ab);
    exp_t e;
    e      = '0;
    e.v    = v;
    e.s    = SW'(s);
    e.busy = b;
    e.ov   = ov;
    e.done = d;
    e.ab   = ab;
    return e;
  endfunction

  function automatic logic [31:0] obs();
    return 32'({valve_open, stage_idx, busy, out_valid, done, aborted});
  endfunction

  function automatic logic [31:0] expv(input exp_t e);
    return 32'({e.v, e.s, e.busy, e.ov, e.done, e.ab});
  endfunction

  // Single-valve / break-before-make invariant, sampled on the falling edge.
  logic [NS-1:0] prev_v = '0;
  always @(negedge clk) begin
    if (!rst) begin
      check("onehot", 32'($countones(valve_open) <= 1), 32'd1);
      check("bbm", 32'((prev_v != '0) && (valve_open != '0) && (prev_v != valve_open)), 32'd0);
      prev_v = valve_open;
    end else begin
      prev_v = '0;
    end
  end

  // abort_mode: 0 none, 1 first cycle of stage 3 open, 2 last collect cycle (with ack), 3 random busy cycle
  task automatic run_seq(input logic [CW-1:0] dw [NS], input int passes, input int ackd,
                         input int abort_mode, input bit noise, input bit rst_mode);
    exp_t q[$];
    exp_t e;
    int   np;
    int   nd;
    int   abort_at;
    int   rst_at;

    np = (passes == 0) ? 1 : passes;
    for (int p = 0; p < np; p++) begin
      if (p > 0) repeat (G) q.push_back(mk('0, 0, 1'b1, 1'b0, 1'b0, 1'b0));
      for (int k = 0; k < NS; k++) begin
        if (k > 0) repeat (G) q.push_back(mk('0, k - 1, 1'b1, 1'b0, 1'b0, 1'b0));
        nd = (dw[k] == '0) ? 1 : int'(dw[k]);
        repeat (nd) q.push_back(mk(NS'(1) << k, k, 1'b1, 1'b0, 1'b0, 1'b0));
      end
      for (int c = 0; c < ackd; c++) begin
        e = mk('0, NS - 1, 1'b1, 1'b1, 1'b0, 1'b0);
        e.ack = (c == ackd - 1);
        q.push_back(e);
      end
    end

    abort_at = -1;
    case (abort_mode)
      1: for (int i = 0; i < q.size(); i++)
           if (abort_at < 0 && q[i].v == NS'(8)) abort_at = i;
      2: abort_at = q.size() - 1;
      3: abort_at = int'($urandom_range(0, q.size() - 1));
      default: abort_at = -1;
    endcase

    if (abort_at >= 0) begin
      q = q[0:abort_at];
      e = q[abort_at];
      e.abt = 1'b1;
      q[abort_at] = e;
      q.push_back(mk('0, 0, 1'b0, 1'b0, 1'b0, 1'b1));
    end else begin
      q.push_back(mk('0, 0, 1'b0, 1'b0, 1'b1, 1'b0));
    end
    q.push_back(mk('0, 0, 1'b0, 1'b0, 1'b0, 1'b0));

    rst_at = -1;
    if (rst_mode)
      for (int i = 1; i < q.size(); i++)
        if (rst_at < 0 && q[i].busy && q[i].v == '0 && !q[i].ov) rst_at = i;

    for (int k = 0; k < NS; k++) dwell_cfg[k*CW +: CW] = dw[k];
    num_passes = PW'(passes);
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;

    for (int i = 0; i < q.size(); i++) begin
      check("cycle", obs(), expv(q[i]));
      if (i == rst_at) begin
        #2 rst = 1'b1;
        #1 check("async_rst", obs(), 32'd0);
        #2 rst = 1'b0;
        out_ack = 1'b0;
        abort   = 1'b0;
        start   = 1'b0;
        @(posedge clk);
        #1 check("post_rst_idle", obs(), 32'd0);
        return;
      end
      out_ack = q[i].ack;
      abort   = q[i].abt;
      if (noise && q[i].busy) begin
        start = 1'($urandom_range(0, 1));
        for (int k = 0; k < NS; k++) dwell_cfg[k*CW +: CW] = CW'($urandom);
        num_passes = PW'($urandom);
      end else begin
        start = 1'b0;
      end
      if (i < q.size() - 1) begin
        @(posedge clk);
        #1;
      end
    end
    out_ack = 1'b0;
    abort   = 1'b0;
    start   = 1'b0;
  endtask

  logic [CW-1:0] dw [NS];

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    out_ack    = 1'b0;
    dwell_cfg  = '0;
    num_passes = '0;
    #2 check("reset", obs(), 32'd0);
    #10 rst = 1'b0;

    // Abort and start in IDLE: nothing happens.
    abort = 1'b1;
    @(posedge clk);
    #1 check("idle_abort", obs(), 32'd0);
    start = 1'b1;
    @(posedge clk);
    #1 check("idle_abort_start", obs(), 32'd0);
    abort = 1'b0;
    start = 1'b0;

    dw = '{16'd3, 16'd1, 16'd5, 16'd2, 16'd2, 16'd4};
    run_seq(dw, 1, 2, 0, 1'b0, 1'b0);

    dw = '{16'd2, 16'd1, 16'd0, 16'd1, 16'hFFFF, 16'd1};
    run_seq(dw, 1, 1, 0, 1'b0, 1'b0);

    dw = '{16'd1, 16'd2, 16'd1, 16'd3, 16'd1, 16'd2};
    run_seq(dw, 3, 1, 0, 1'b0, 1'b0);
    run_seq(dw, 0, 3, 0, 1'b0, 1'b0);

    dw = '{16'd3, 16'd1, 16'd5, 16'd2, 16'd2, 16'd4};
    run_seq(dw, 2, 2, 1, 1'b0, 1'b0);
    run_seq(dw, 1, 2, 2, 1'b0, 1'b0);
    run_seq(dw, 1, 2, 0, 1'b0, 1'b0);

    run_seq(dw, 2, 2, 0, 1'b1, 1'b0);

    run_seq(dw, 1, 1, 0, 1'b0, 1'b1);
    run_seq(dw, 1, 1, 0, 1'b0, 1'b0);

    for (int r = 0; r < 12; r++) begin
      for (int k = 0; k < NS; k++) dw[k] = CW'($urandom_range(0, 6));
      run_seq(dw, int'($urandom_range(0, 3)), int'($urandom_range(1, 3)),
              (r % 4 == 3) ? 3 : 0, (r % 2) == 1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
